vec_serializer: RTL



---
 rtl/vec_serializer_if.sv | 30 +++
 rtl/vec_serializer.sv | 71 +++++++
 2 files changed

// File: rtl/vec_serializer_if.sv
// Handshake bundle between a parallel vector producer, the serializer and a
// narrow per-beat consumer. Signal names are seen from the serializer side.
interface vec_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 10
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] din [NUM_REGS];
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic [IDX_W-1:0]      o_index;
    logic                  o_last;
    logic                  o_busy;

    // Serializer side
    modport slave (
        input  i_valid, din, i_ready,
        output o_ready, o_valid, dout, o_index, o_last, o_busy
    );

    // Producer/consumer side
    modport master (
        output i_valid, din, i_ready,
        input  o_ready, o_valid, dout, o_index, o_last, o_busy
    );
endinterface

// File: rtl/vec_serializer.sv
// Vector serializer: captures NUM_REGS words in one handshake and streams them
// out one word per beat with index and last flag. A new vector may be taken on
// the last beat of the current one, so back-to-back vectors have no bubble.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no vector held; ready to capture, o_valid low
// STREAM | vector held in r_buf; presenting element r_idx downstream
module vec_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 10
) (
    input  logic             clk,
    input  logic             rst,
    vec_serializer_if.slave  bus
);
    localparam int             IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_buf [NUM_REGS];

    logic w_valid;
    logic w_last;
    logic w_beat;
    logic w_ready;
    logic w_cap;

    // Handshake decode; the i_ready -> o_ready path lets the last beat and
    // the next capture share one edge.
    assign w_valid = (r_state == STREAM);
    assign w_last  = (r_idx == LAST_IDX);
    assign w_beat  = w_valid && bus.i_ready;
    assign w_ready = (r_state == IDLE) || (w_beat && w_last);
    assign w_cap   = bus.i_valid && w_ready;

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_busy  = w_valid;
    assign bus.o_last  = w_last;
    assign bus.o_index = r_idx;
    assign bus.dout    = r_buf[r_idx];

    // Sequencer: capture a whole vector, then advance one element per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_cap) begin
            r_buf   <= bus.din;
            r_idx   <= '0;
            r_state <= STREAM;
        end else if (w_beat) begin
            if (w_last) begin
                r_state <= IDLE;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
            end
        end
    end
endmodule
